// File: rtl/seg_scan_ctrl.sv
// Six-digit common-anode seven-segment scan controller. Frames arrive through a
// valid/ready handshake, are double-buffered, and are swapped in only at frame boundaries.
module seg_scan_ctrl #(
    parameter int DWELL_CYC = 50000,
    parameter int GUARD_CYC = 500
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [23:0] upd_data,
    input  logic [5:0]  upd_point,
    input  logic        upd_lzs,
    input  logic        disp_en,
    output logic [7:0]  seg_led,
    output logic [5:0]  seg_sel,
    output logic        frame_done
);

    localparam int MAX_CYC = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] GUARD_LAST = (GUARD_CYC > 0) ? CW'(GUARD_CYC - 1) : '0;
    localparam logic [13:0]   BLANK      = {6'h3F, 8'hFF};

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_DWELL
    } state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [23:0]   shd_data, act_data;
    logic [5:0]    shd_point, act_point;
    logic          shd_lzs, act_lzs;
    logic          pending;

    // Handshake: upd_valid/upd_ready both high at a rising edge moves the offered frame
    // into the shadow buffer; upd_ready stays low until that frame reaches the active buffer.
    logic        capture, boundary, transfer;
    logic        dwell_last, guard_last;
    logic [2:0]  idx_inc;
    logic [23:0] act_data_n;
    logic [5:0]  act_point_n;
    logic        act_lzs_n;

    assign dwell_last  = (cnt == DWELL_LAST);
    assign guard_last  = (cnt == GUARD_LAST);
    assign idx_inc     = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    assign capture     = upd_valid && upd_ready;
    assign boundary    = disp_en && (state == S_DWELL) && dwell_last && (idx == 3'd5);
    assign transfer    = pending && (boundary || (state == S_IDLE));
    // Lit outputs registered on a transfer edge must already reflect the incoming frame.
    assign act_data_n  = transfer ? shd_data  : act_data;
    assign act_point_n = transfer ? shd_point : act_point;
    assign act_lzs_n   = transfer ? shd_lzs   : act_lzs;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Returns {seg_sel, seg_led} for digit i lit from the given frame.
    function automatic logic [13:0] drive(input logic [2:0] i, input logic [23:0] d,
                                          input logic [5:0] p, input logic z);
        logic [23:0] upper;
        logic [6:0]  seg;
        logic [5:0]  sel;
        upper = d >> {i, 2'b00};
        // A digit is a leading zero when it and every digit above it are zero.
        seg   = (z && (i != 3'd0) && (upper == 24'd0)) ? 7'h7F : decode(upper[3:0]);
        sel   = ~(6'b000001 << i);
        return {sel, ~p[i], seg};
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending   <= 1'b0;
            upd_ready <= 1'b1;
            shd_data  <= '0;
            shd_point <= '0;
            shd_lzs   <= 1'b0;
            act_data  <= '0;
            act_point <= '0;
            act_lzs   <= 1'b0;
        end else begin
            if (capture) begin
                shd_data  <= upd_data;
                shd_point <= upd_point;
                shd_lzs   <= upd_lzs;
                pending   <= 1'b1;
                upd_ready <= 1'b0;
            end else if (transfer) begin
                pending   <= 1'b0;
                upd_ready <= 1'b1;
            end
            act_data  <= act_data_n;
            act_point <= act_point_n;
            act_lzs   <= act_lzs_n;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state              <= S_IDLE;
            idx                <= 3'd0;
            cnt                <= '0;
            frame_done         <= 1'b0;
            {seg_sel, seg_led} <= BLANK;
        end else begin
            frame_done <= 1'b0;
            if (!disp_en) begin
                state              <= S_IDLE;
                idx                <= 3'd0;
                cnt                <= '0;
                {seg_sel, seg_led} <= BLANK;
            end else begin
                case (state)
                    S_IDLE: begin
                        idx <= 3'd0;
                        cnt <= '0;
                        if (GUARD_CYC == 0) begin
                            state              <= S_DWELL;
                            {seg_sel, seg_led} <= drive(3'd0, act_data_n, act_point_n, act_lzs_n);
                        end else begin
                            state              <= S_GUARD;
                            {seg_sel, seg_led} <= BLANK;
                        end
                    end
                    S_GUARD: begin
                        if (guard_last) begin
                            state              <= S_DWELL;
                            cnt                <= '0;
                            {seg_sel, seg_led} <= drive(idx, act_data_n, act_point_n, act_lzs_n);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DWELL: begin
                        if (dwell_last) begin
                            cnt        <= '0;
                            idx        <= idx_inc;
                            frame_done <= (idx == 3'd5);
                            if (GUARD_CYC == 0) begin
                                {seg_sel, seg_led} <= drive(idx_inc, act_data_n, act_point_n, act_lzs_n);
                            end else begin
                                state              <= S_GUARD;
                                {seg_sel, seg_led} <= BLANK;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state              <= S_IDLE;
                        idx                <= 3'd0;
                        cnt                <= '0;
                        {seg_sel, seg_led} <= BLANK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DWELL_CYC=4, GUARD_CYC=2 (digit period 6, frame 36).
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [23:0] upd_data = '0;
    logic [5:0]  upd_point = '0;
    logic        upd_lzs = 1'b0;
    logic        disp_en = 1'b0;
    logic [7:0]  seg_led;
    logic [5:0]  seg_sel;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_ctrl #(.DWELL_CYC(4), .GUARD_CYC(2)) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_data   (upd_data),
        .upd_point  (upd_point),
        .upd_lzs    (upd_lzs),
        .disp_en    (disp_en),
        .seg_led    (seg_led),
        .seg_sel    (seg_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_blank(input string tag);
        check(tag, {26'd0, seg_sel, seg_led}, {26'd0, 6'h3F, 8'hFF});
    endtask

    task automatic wait_fd();
        int n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("fd_wait", {31'd0, frame_done}, 32'd1);
    endtask

    // Offers a frame, holds it until accepted, then drops upd_valid.
    task automatic send_frame(input logic [23:0] d, input logic [5:0] p, input logic z);
        int n = 0;
        upd_data  = d;
        upd_point = p;
        upd_lzs   = z;
        upd_valid = 1'b1;
        while (upd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", {31'd0, upd_ready}, 32'd1);
        tick();
        upd_valid = 1'b0;
        check("cap_ready_low", {31'd0, upd_ready}, 32'd0);
    endtask

    task automatic send_mid(input logic [23:0] d, input logic [5:0] p, input logic z);
        wait_fd();
        repeat (10) tick();
        send_frame(d, p, z);
    endtask

    // Starts at the cycle frame_done is high (first guard cycle of digit 0) and walks one
    // whole frame, ending on the next frame_done cycle. leds = {d5,...,d0}.
    task automatic expect_frame(input bit wait_first, input logic [47:0] leds, input string tag);
        logic [5:0] sel;
        logic [7:0] led;
        if (wait_first) wait_fd();
        for (int k = 0; k < 6; k++) begin
            sel = ~(6'b000001 << k);
            led = leds[k*8 +: 8];
            tick();
            check_blank({tag, "_guard"});
            for (int c = 0; c < 4; c++) begin
                tick();
                check({tag, "_sel"}, {26'd0, seg_sel}, {26'd0, sel});
                check({tag, "_led"}, {24'd0, seg_led}, {24'd0, led});
            end
            tick();
            check({tag, "_fd"}, {31'd0, frame_done}, {31'd0, (k == 5)});
            check_blank({tag, "_gap"});
        end
    endtask

    initial begin
        int early;
        int n;
        int fd_cnt;

        // 1: reset and idle
        repeat (3) tick();
        check("rst_vals", {18'd0, seg_sel, seg_led, upd_ready, frame_done},
              {18'd0, 6'h3F, 8'hFF, 1'b1, 1'b0});
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_out", {18'd0, seg_sel, seg_led, upd_ready, frame_done},
                  {18'd0, 6'h3F, 8'hFF, 1'b1, 1'b0});
        end

        // 2: load in IDLE, transfer on the next IDLE edge, then enable
        send_frame(24'h123456, 6'b000100, 1'b0);
        tick();
        check("idle_xfer_ready", {31'd0, upd_ready}, 32'd1);
        disp_en = 1'b1;
        tick();
        check_blank("en_guard1");
        tick();
        check_blank("en_guard2");
        for (int c = 0; c < 4; c++) begin
            tick();
            check("en_d0_sel", {26'd0, seg_sel}, {26'd0, 6'h3E});
            check("en_d0_led", {24'd0, seg_led}, 32'h82);
        end
        tick();
        check_blank("en_d0_after");
        expect_frame(1'b1, {8'hF9, 8'hA4, 8'hB0, 8'h19, 8'h92, 8'h82}, "f123456");

        // 3: leading-zero suppression
        send_mid(24'h000070, 6'b000000, 1'b1);
        expect_frame(1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hC0}, "lzs70");
        send_mid(24'h000000, 6'b000000, 1'b1);
        expect_frame(1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, "lzs0");

        // 4: mid-frame capture, second offer held until the boundary transfer
        repeat (10) tick();
        send_frame(24'hABCDEF, 6'b000000, 1'b0);
        upd_data  = 24'h654321;
        upd_point = 6'b100000;
        upd_lzs   = 1'b0;
        upd_valid = 1'b1;
        early = 0;
        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (frame_done !== 1'b1 && upd_ready === 1'b1) early++;
        end
        check("hold_fd_seen", {31'd0, frame_done}, 32'd1);
        check("hold_early_ready", early, 32'd0);
        check("hold_ready_at_fd", {31'd0, upd_ready}, 32'd1);
        fork
            expect_frame(1'b0, {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E}, "fABCDEF");
            begin
                tick();
                upd_valid = 1'b0;
                check("second_cap", {31'd0, upd_ready}, 32'd0);
            end
        join
        expect_frame(1'b0, {8'h02, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9}, "f654321");

        // 5: drop disp_en during the digit-3 dwell
        repeat (21) tick();
        check("d3_sel", {26'd0, seg_sel}, {26'd0, 6'h37});
        check("d3_led", {24'd0, seg_led}, 32'h99);
        disp_en = 1'b0;
        tick();
        check_blank("drop_blank");
        fd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_done === 1'b1) fd_cnt++;
        end
        check("drop_no_fd", fd_cnt, 32'd0);
        check_blank("drop_still_blank");
        disp_en = 1'b1;
        tick();
        check_blank("reen_guard1");
        tick();
        check_blank("reen_guard2");
        tick();
        check("reen_d0_sel", {26'd0, seg_sel}, {26'd0, 6'h3E});
        check("reen_d0_led", {24'd0, seg_led}, 32'hF9);

        // 6: asynchronous reset mid-dwell with a frame pending
        send_mid(24'h999999, 6'b111111, 1'b0);
        n = 0;
        while (seg_sel === 6'h3F && n < 20) begin
            tick();
            n++;
        end
        check("pre_rst_lit", {31'd0, (seg_sel !== 6'h3F)}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {18'd0, seg_sel, seg_led, upd_ready, frame_done},
              {18'd0, 6'h3F, 8'hFF, 1'b1, 1'b0});
        disp_en = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_blank("post_rst_blank");
        disp_en = 1'b1;
        expect_frame(1'b1, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}, "fzero");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Multiplexed scan controller for the 6-digit common-anode seven-segment display. It accepts a display frame through a valid/ready handshake and double-buffers it, so the visible value changes only at a frame boundary. It then time-slices the digits with an anti-ghosting blank guard between them. It sits between value producers (counters, timers) and the `seg_led`/`seg_sel` pins, and replaces free-running per-digit drive logic.

## Interface
- `DWELL_CYC`, default 50000: cycles each digit is lit; must be ≥1.
- `GUARD_CYC`, default 500: all-off cycles before each digit; 0 means no guard.
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `upd_valid`  in  1  a new frame is offered.
- `upd_ready`  out  1  shadow buffer is free; capture occurs when `upd_valid && upd_ready` at a rising edge.
- `upd_data`  in  24  six 4-bit digit codes; `[3:0]` = digit 0 (rightmost), `[23:20]` = digit 5.
- `upd_point`  in  6  per-digit decimal point enable; bit i = digit i.
- `upd_lzs`  in  1  leading-zero suppression for this frame.
- `disp_en`  in  1  display enable.
- `seg_led`  out  8  active-low segments; `[6:0]` = g..a, `[7]` = dp.
- `seg_sel`  out  6  active-low digit select; bit i = digit i.
- `frame_done`  out  1  one-cycle pulse at the end of the digit-5 dwell.

## Operation
- Registers:
  - shadow frame (data, point, lzs) plus a `pending` flag;
  - active frame;
  - digit index `idx` (0..5);
  - cycle counter sized by `$clog2` of max(DWELL_CYC, GUARD_CYC);
  - state.
- State machine:
  - IDLE: entered on reset or `disp_en`=0. Outputs blank; `idx`=0; counter=0.
  - IDLE→GUARD when `disp_en`=1. If GUARD_CYC=0, IDLE→DWELL directly.
  - GUARD lasts GUARD_CYC cycles, then →DWELL.
  - DWELL lasts DWELL_CYC cycles, then →GUARD (or DWELL) with `idx`+1.
  - After `idx`=5, `idx` wraps to 0.
- Any state, `disp_en`=0 → IDLE on the next edge. `frame_done` is not pulsed in this case; a partial frame is discarded.
- Output drive:
  - GUARD and IDLE: `seg_sel`=6'h3F, `seg_led`=8'hFF.
  - DWELL: `seg_sel`=~(1<<idx); `seg_led[6:0]` = decode of active digit[idx]; `seg_led[7]`=~point[idx].
- Decode (active-low, dp=1 shown):
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
  - 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E
- Leading-zero suppression, when active lzs=1:
  - Digit i (i=5..1) is blanked (`seg_led[6:0]`=7'h7F) if it and all higher digits are 0.
  - Digit 0 is never blanked.
  - The dp of a blanked digit is still driven from point[i].
- Handshake:
  - On capture: shadow ← inputs, `pending` ← 1.
  - `upd_ready` = ~`pending`, registered.
  - Transfer (active ← shadow, `pending` ← 0) occurs:
    - at the frame-boundary edge, i.e. the edge ending the digit-5 dwell, coincident with `frame_done`; or
    - on any IDLE edge while `pending`=1.
- Simultaneous events:
  - Capture on the same edge as a frame boundary with `pending`=0: data goes to shadow only, with no same-edge transfer. It is shown from the next boundary.
  - `upd_valid` while `upd_ready`=0 is ignored; producers hold data until accepted.

## Timing
- Reset values:
  - `seg_sel`=6'h3F, `seg_led`=8'hFF, `upd_ready`=1, `frame_done`=0;
  - state IDLE, `idx`=0, `pending`=0;
  - active and shadow frames all zero, lzs=0.
- All outputs are registered and aligned with state: the first lit cycle of a digit is the cycle after its last guard cycle.
- Digit period = GUARD_CYC+DWELL_CYC. Frame period = 6×(GUARD_CYC+DWELL_CYC); `frame_done` pulses are exactly that far apart.
- Capture → `upd_ready` low on the next cycle.
- Transfer → `upd_ready` high on the next cycle; new data is visible from digit 0 of the following frame.
- `disp_en` rise → first lit cycle after GUARD_CYC+1 cycles.
- `disp_en` fall → blank on the next cycle.
- Mid-operation reset → immediate reset values; the pending frame is lost.

## Test plan
Use `DWELL_CYC`=4, `GUARD_CYC`=2 throughout.

1. Reset, with `disp_en`=0 → `seg_sel`=3F, `seg_led`=FF, `upd_ready`=1, no `frame_done` for 100 cycles.
2. In IDLE, load `upd_data`=24'h123456, `upd_point`=6'b000100, lzs=0, then raise `disp_en` →
   - digit 0 shows 82 with `seg_sel`=3E for 4 cycles after 2 blank cycles;
   - digit 2 shows 19; digit 5 shows F9;
   - `frame_done` every 36 cycles.
3. With lzs=1, `upd_data`=24'h000070 → digits 5..2 show FF, digit 1 shows F8, digit 0 shows C0. With `upd_data`=0, only digit 0 shows C0.
4. Mid-frame capture of 24'hABCDEF →
   - `upd_ready` low until the cycle after the next `frame_done`;
   - a second held `upd_valid` is accepted only then;
   - the next frame shows digits 5..0 = 88, 83, C6, A1, 86, 8E.
5. Drop `disp_en` during the digit-3 dwell → blank next cycle, no `frame_done`. Re-raise → 2 guard cycles, then digit 0.
6. Assert `sys_rst_n`=0 mid-dwell with `pending`=1 → outputs immediately 3F/FF, `upd_ready`=1. After release, the display shows all zeros (C0 on every digit) once enabled.
